// File: rtl/osd_u8g2_tx.sv
// Transmit end of the u8g2-layout OSD byte link: shadow framebuffer, dirty-tile
// tracking and a paced strobe/start/data serialiser for visibility and tile messages.
module osd_u8g2_tx #(
  parameter int STROBE_GAP = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [9:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       show,
  input  logic       flush,
  output logic       busy,
  output logic       data_out_strobe,
  output logic       data_out_start,
  output logic [7:0] data_out
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] VIS_CMD   = 3'd1;
  localparam logic [2:0] VIS_ARG   = 3'd2;
  localparam logic [2:0] TILE_CMD  = 3'd3;
  localparam logic [2:0] TILE_IDX  = 3'd4;
  localparam logic [2:0] TILE_DATA = 3'd5;
  localparam logic [2:0] GAP       = 3'd6;

  localparam logic [3:0] GAP_LEN      = 4'(STROBE_GAP);
  // A data byte needs its registered RAM read one cycle ahead, so never skip the gap.
  localparam logic [3:0] DATA_GAP_LEN = (STROBE_GAP == 0) ? 4'd1 : 4'(STROBE_GAP);

  logic [2:0]   state_q, state_d, nxt_q, nxt_d;
  logic [3:0]   gap_cnt_q, gap_cnt_d;
  logic [127:0] dirty_q, dirty_d;
  logic         shown_sent_q, shown_sent_d;
  logic [6:0]   ptr_q, ptr_d, idx_q, idx_d;
  logic [2:0]   byte_cnt_q, byte_cnt_d;
  logic         strobe_q, strobe_d, start_q, start_d, busy_q, busy_d;
  logic [7:0]   data_q, data_d;

  logic [7:0]   shadow [1024];
  logic [7:0]   rd_data_q;
  logic [9:0]   rd_addr;

  logic         emit, clear_tile;
  logic [2:0]   emit_nxt;
  logic [3:0]   emit_len;

  assign rd_addr = {idx_q, byte_cnt_q};

  // Same-cycle write forwarding keeps the snapshot as late as possible.
  always_ff @(posedge clk) begin
    if (wr_en) shadow[wr_addr] <= wr_data;
    rd_data_q <= (wr_en && (wr_addr == rd_addr)) ? wr_data : shadow[rd_addr];
  end

  always_comb begin
    state_d      = state_q;
    nxt_d        = nxt_q;
    gap_cnt_d    = gap_cnt_q;
    dirty_d      = dirty_q;
    shown_sent_d = shown_sent_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    byte_cnt_d   = byte_cnt_q;
    strobe_d     = 1'b0;
    start_d      = start_q;
    data_d       = data_q;
    busy_d       = (state_q != IDLE);
    emit         = 1'b0;
    clear_tile   = 1'b0;
    emit_nxt     = IDLE;
    emit_len     = GAP_LEN;

    case (state_q)
      IDLE: begin
        if (show != shown_sent_q) begin
          shown_sent_d = show;
          state_d      = VIS_CMD;
        end else if (dirty_q[ptr_q]) begin
          idx_d      = ptr_q;
          byte_cnt_d = 3'd0;
          clear_tile = 1'b1;
          state_d    = TILE_CMD;
        end else begin
          ptr_d = ptr_q + 7'd1;
        end
      end
      VIS_CMD: begin
        emit     = 1'b1;
        start_d  = 1'b1;
        data_d   = 8'h01;
        emit_nxt = VIS_ARG;
      end
      VIS_ARG: begin
        emit    = 1'b1;
        start_d = 1'b0;
        data_d  = {7'b0, shown_sent_q};
      end
      TILE_CMD: begin
        emit     = 1'b1;
        start_d  = 1'b1;
        data_d   = 8'h02;
        emit_nxt = TILE_IDX;
      end
      TILE_IDX: begin
        emit     = 1'b1;
        start_d  = 1'b0;
        data_d   = {1'b0, idx_q};
        emit_nxt = TILE_DATA;
        emit_len = DATA_GAP_LEN;
      end
      TILE_DATA: begin
        emit    = 1'b1;
        start_d = 1'b0;
        data_d  = rd_data_q;
        if (byte_cnt_q == 3'd7) begin
          ptr_d = idx_q + 7'd1;
        end else begin
          byte_cnt_d = byte_cnt_q + 3'd1;
          emit_nxt   = TILE_DATA;
          emit_len   = DATA_GAP_LEN;
        end
      end
      GAP: begin
        if (gap_cnt_q == 4'd0) state_d = nxt_q;
        else gap_cnt_d = gap_cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
      strobe_d = 1'b1;
      if (emit_len == 4'd0) begin
        state_d = emit_nxt;
      end else begin
        state_d   = GAP;
        nxt_d     = emit_nxt;
        gap_cnt_d = emit_len - 4'd1;
      end
    end

    // Clear first so a same-cycle write or flush re-marks the tile.
    if (clear_tile) dirty_d[ptr_q] = 1'b0;
    if (flush) dirty_d = '1;
    if (wr_en) dirty_d[wr_addr[9:3]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      nxt_q        <= IDLE;
      gap_cnt_q    <= 4'd0;
      dirty_q      <= '0;
      shown_sent_q <= 1'b0;
      ptr_q        <= 7'd0;
      idx_q        <= 7'd0;
      byte_cnt_q   <= 3'd0;
      strobe_q     <= 1'b0;
      start_q      <= 1'b0;
      data_q       <= 8'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      nxt_q        <= nxt_d;
      gap_cnt_q    <= gap_cnt_d;
      dirty_q      <= dirty_d;
      shown_sent_q <= shown_sent_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      byte_cnt_q   <= byte_cnt_d;
      strobe_q     <= strobe_d;
      start_q      <= start_d;
      data_q       <= data_d;
      busy_q       <= busy_d;
    end
  end

  assign busy            = busy_q;
  assign data_out_strobe = strobe_q;
  assign data_out_start  = start_q;
  assign data_out        = data_q;

endmodule

// File: tb/tb_osd_u8g2_tx.sv
// Directed bench for osd_u8g2_tx: captures every strobed byte and compares it
// against messages built from a local shadow model.
module tb_osd_u8g2_tx;
  localparam int G = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [9:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       show = 1'b0;
  logic       flush = 1'b0;
  logic       busy, data_out_strobe, data_out_start;
  logic [7:0] data_out;

  osd_u8g2_tx #(.STROBE_GAP(G)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .show(show), .flush(flush), .busy(busy), .data_out_strobe(data_out_strobe),
    .data_out_start(data_out_start), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_cyc = 0;
  bit have_last = 0;
  logic [8:0] last_byte = '0;
  int gap_viol = 0;
  int hold_viol = 0;
  bit busy_seen = 0;
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] mdl [1024];

  always @(posedge clk) cyc <= cyc + 1;

  // Byte capture, strobe spacing and hold-between-strobes monitoring.
  always @(negedge clk) begin
    if (reset) begin
      have_last = 0;
      last_byte = '0;
    end else if (data_out_strobe) begin
      rx_q.push_back({data_out_start, data_out});
      if (have_last && (cyc - last_cyc) < G + 1) gap_viol++;
      last_cyc  = cyc;
      have_last = 1;
      last_byte = {data_out_start, data_out};
    end else if ({data_out_start, data_out} !== last_byte) begin
      hold_viol++;
    end
    if (busy) busy_seen = 1;
  end

  task automatic do_write(input logic [9:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d; mdl[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_tile(input int idx);
    exp_q.push_back({1'b1, 8'h02});
    exp_q.push_back({2'b0, 7'(idx)});
    for (int i = 0; i < 8; i++) exp_q.push_back({1'b0, mdl[idx*8 + i]});
  endtask

  task automatic wait_quiet(input string name);
    int idle = 0;
    int n = 0;
    while (idle < 300 && n < 20000) begin
      @(negedge clk);
      n++;
      if (!busy && !data_out_strobe) idle++;
      else idle = 0;
    end
    checks++;
    if (idle < 300) begin
      failures++;
      $display("FAIL %s_quiet_timeout cycles=%0d required_idle=300", name, n);
    end
  endtask

  task automatic wait_rx(input int cnt, input string name);
    int n = 0;
    while (rx_q.size() < cnt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rx_q.size() < cnt) begin
      failures++;
      $display("FAIL %s_rx_timeout got=%0d required=%0d", name, rx_q.size(), cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, data_out_strobe, data_out_start, data_out} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h required=000", {busy, data_out_strobe, data_out_start, data_out});
    end
    rx_q.delete();
    busy_seen = 0;
    repeat (500) @(negedge clk);
    checks++;
    if (rx_q.size() != 0) begin
      failures++;
      $display("FAIL reset_idle_strobes got=%0d required=0", rx_q.size());
    end
    checks++;
    if (busy_seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle_busy got=%b required=0", busy_seen);
    end
  endtask

  task automatic test_visibility(input logic val);
    rx_q.delete();
    exp_q.delete();
    exp_q.push_back({1'b1, 8'h01});
    exp_q.push_back({1'b0, 7'b0, val});
    @(negedge clk);
    show = val;
    wait_quiet("vis");
    checks++;
    if (rx_q.size() != 2) begin
      failures++;
      $display("FAIL vis_count show=%b got=%0d required=2", val, rx_q.size());
    end
    for (int i = 0; i < 2 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL vis_byte%0d show=%b got=%h required=%h", i, val, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic preload();
    for (int a = 0; a < 1024; a++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = 10'(a); wr_data = 8'(a * 13 + 7); mdl[a] = 8'(a * 13 + 7);
    end
    @(negedge clk);
    wr_en = 1'b0;
    wait_quiet("preload");
  endtask

  task automatic test_tile127();
    rx_q.delete();
    exp_q.delete();
    do_write(10'h3F9, 8'hA5);
    push_tile(127);
    wait_quiet("tile127");
    checks++;
    if (rx_q.size() != 10) begin
      failures++;
      $display("FAIL tile127_count got=%0d required=10", rx_q.size());
    end
    for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL tile127_byte%0d got=%h required=%h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    rx_q.delete();
    exp_q.delete();
    do_write(10'h018, 8'h33);
    wait_rx(1, "rr");
    do_write(10'h02A, 8'h5A);
    do_write(10'h01B, mdl[10'h01B]);
    push_tile(3);
    push_tile(5);
    push_tile(3);
    wait_quiet("rr");
    checks++;
    if (rx_q.size() != 30) begin
      failures++;
      $display("FAIL rr_count got=%0d required=30", rx_q.size());
    end
    for (int i = 0; i < 30 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rr_byte%0d got=%h required=%h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mid_write();
    rx_q.delete();
    exp_q.delete();
    do_write(10'h048, 8'h11);
    wait_rx(2, "midwr");
    do_write(10'h04C, 8'hC4);
    push_tile(9);
    push_tile(9);
    wait_quiet("midwr");
    checks++;
    if (rx_q.size() != 20) begin
      failures++;
      $display("FAIL midwr_count got=%0d required=20", rx_q.size());
    end
    for (int i = 0; i < 20 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL midwr_byte%0d got=%h required=%h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_flush();
    rx_q.delete();
    exp_q.delete();
    do_write(10'h3F8, mdl[10'h3F8]);
    wait_rx(1, "flush");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    push_tile(127);
    for (int t = 0; t < 128; t++) push_tile(t);
    wait_quiet("flush");
    checks++;
    if (rx_q.size() != 1290) begin
      failures++;
      $display("FAIL flush_count got=%0d required=1290", rx_q.size());
    end
    for (int i = 0; i < 1290 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL flush_byte%0d got=%h required=%h", i, rx_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_message();
    rx_q.delete();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_rx(5, "midrst");
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (data_out_strobe !== 1'b0) begin
      failures++;
      $display("FAIL midrst_strobe got=%b required=0", data_out_strobe);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_busy got=%b required=0", busy);
    end
    checks++;
    if ({data_out_start, data_out} !== 9'd0) begin
      failures++;
      $display("FAIL midrst_data got=%h required=000", {data_out_start, data_out});
    end
    @(negedge clk);
    reset = 1'b0;
    rx_q.delete();
    repeat (300) @(negedge clk);
    checks++;
    if (rx_q.size() != 0) begin
      failures++;
      $display("FAIL midrst_after_strobes got=%0d required=0", rx_q.size());
    end
  endtask

  task automatic test_pacing();
    checks++;
    if (gap_viol != 0) begin
      failures++;
      $display("FAIL pacing_gap violations=%0d required=0", gap_viol);
    end
    checks++;
    if (hold_viol != 0) begin
      failures++;
      $display("FAIL pacing_hold violations=%0d required=0", hold_viol);
    end
  endtask

  initial begin
    test_reset();
    test_visibility(1'b1);
    test_visibility(1'b0);
    preload();
    test_tile127();
    test_round_robin();
    test_mid_write();
    test_flush();
    test_pacing();
    test_reset_mid_message();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/osd_u8g2_tx.md
Name: osd_u8g2_tx

Overview:
- Transmit end of the u8g2-layout OSD byte link.
- Holds a local 1024-byte shadow of the 128x64 OSD framebuffer and tracks which 8-byte tiles have changed (dirty tiles).
- Serialises those tiles, plus show/hide changes, into the strobe/start/data byte stream that the OSD renderer consumes.
- Sits between the control core (menu firmware writing pixels) and the OSD overlay in the video path.

Parameters:
- STROBE_GAP, 3: minimum idle cycles between two data_out_strobe pulses (range 0..15).

Ports:
- clk  in  1  system clock
- reset  in  1  sync, active-high
- wr_en  in  1  shadow buffer write enable
- wr_addr  in  10  shadow byte address; tile = wr_addr[9:3]
- wr_data  in  8  shadow byte data
- show  in  1  requested OSD visibility (level)
- flush  in  1  one-cycle pulse: mark all 128 tiles dirty
- busy  out  1  high while a message is being emitted
- data_out_strobe  out  1  one-cycle byte-valid pulse
- data_out_start  out  1  qualifies strobe: byte is a command (first byte of a message)
- data_out  out  8  byte value, valid only while strobe=1

Behaviour:
- Reset: all outputs 0; dirty[127:0]=0; shown_sent=0; scan pointer=0; FSM=IDLE. Shadow RAM contents are not reset.
- Clock and reset are exactly as decided: reset is synchronous and active-high; clk is the only clock.
- Message formats (every byte is one strobe):
  - Visibility: start byte 0x01, then payload {7'b0, shown}.
  - Tile: start byte 0x02, then {1'b0, idx[6:0]}, then 8 bytes shadow[idx*8+0 .. idx*8+7] in ascending order.
  - data_out_start=1 only on the command byte.
- Pacing:
  - Strobes are single-cycle.
  - Between consecutive strobes there are at least STROBE_GAP cycles with strobe=0, inside and between messages.
  - data_out and data_out_start hold their values from each strobe until the next strobe.
- Write port:
  - wr_en writes shadow[wr_addr] and sets dirty[wr_addr[9:3]] in the same cycle.
  - The write is accepted every cycle, including while busy.
- flush sets all dirty bits. If a write and a flush occur in the same cycle, both take effect.
- FSM states: IDLE, VIS_CMD, VIS_ARG, TILE_CMD, TILE_IDX, TILE_DATA(0..7), GAP.
- IDLE priority:
  1. If show != shown_sent: latch shown_sent<=show and emit the visibility message.
  2. Otherwise, if dirty[ptr]: latch idx=ptr, clear dirty[ptr], and emit the tile message.
  3. Otherwise ptr<=ptr+1 (wraps 127->0). One tile is examined per idle cycle.
- After a tile message: ptr<=idx+1 (round-robin fairness).
- Dirty clear versus a same-cycle write to the same tile: the set wins, so the tile stays dirty and is re-sent later.
- Snapshot timing: each data byte is read from shadow RAM when its strobe is issued. A byte written before its strobe goes out is sent with the new value; the tile is also re-marked dirty.
- Shadow read uses a registered (1-cycle) RAM read, issued during the preceding gap. With STROBE_GAP=0 the FSM inserts one read cycle, so the effective spacing is 1.
- show toggling during a tile message is not acted on until IDLE. Back-to-back toggles that return to shown_sent before IDLE produce no message.
- busy=1 from the first strobe of a message through the gap after its last strobe; otherwise 0.
- Reset mid-message aborts immediately: outputs 0, no partial continuation. The receiver resyncs on the next start byte.

Test Plan:
- Reset, show=0, no writes, 500 cycles -> no strobe, busy=0.
- show 0->1 -> exactly 2 strobes: (start=1, 0x01), then (start=0, 0x01); strobe spacing >= STROBE_GAP+1 cycles; show 1->0 -> second payload byte 0x00.
- Write 0xA5 to addr 0x3F9 -> one tile message: 0x02(start), 0x7F, then shadow[0x3F8..0x3FF] with byte 1 = 0xA5. dirty[127] clears; no further messages.
- Writes to tiles 5 and 3 in the same window with ptr=4 -> tile 5 sent before tile 3 (round-robin); each tile sent exactly once.
- During transmission of tile 9, write addr 0x04C -> new value appears in the current message (byte 4 not yet sent) and tile 9 is re-sent once more.
- flush after loading a known pattern -> 128 tile messages of 10 strobes each, indices 0..127 in order from ptr=0; assert reset mid-message -> strobe=0 next cycle, busy=0.
